// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/off events to VOICES envelope
// generators, reusing a matching, free or released voice or stealing the oldest.
module voice_allocator #(
  parameter int unsigned VOICES        = 4,
  parameter int unsigned NOTE_BITS     = 7,
  parameter int unsigned VELOCITY_BITS = 7,
  parameter int unsigned AGE_BITS      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            event_valid,
  output logic                            event_ready,
  input  logic                            event_on,
  input  logic [NOTE_BITS-1:0]            event_note,
  input  logic [VELOCITY_BITS-1:0]        event_velocity,
  input  logic [VOICES-1:0]               voice_active,
  output logic [VOICES-1:0]               gate,
  output logic [VOICES*NOTE_BITS-1:0]     voice_note,
  output logic [VOICES*VELOCITY_BITS-1:0] voice_velocity
);

  localparam int unsigned IDX_BITS = $clog2(VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(VOICES - 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {IDLE, SCAN, STEAL, ASSIGN, RELEASE} state_t;

  state_t                   state;
  logic [IDX_BITS-1:0]      idx, target;
  logic                     ev_on;
  logic [NOTE_BITS-1:0]     ev_note;
  logic [VELOCITY_BITS-1:0] ev_vel;
  logic                     match_found, free_found, rel_found, old_found;
  logic [IDX_BITS-1:0]      match_idx, free_idx, rel_idx, old_idx;
  logic [AGE_BITS-1:0]      old_age;

  logic [NOTE_BITS-1:0]     note_q [VOICES];
  logic [VELOCITY_BITS-1:0] vel_q  [VOICES];
  logic [AGE_BITS-1:0]      age_q  [VOICES];

  logic                     hit_match, hit_free, hit_rel, hit_old;
  logic [IDX_BITS-1:0]      match_sel, free_sel, rel_sel, old_sel;

  assign event_ready = (state == IDLE);

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign voice_note[g*NOTE_BITS +: NOTE_BITS]             = note_q[g];
    assign voice_velocity[g*VELOCITY_BITS +: VELOCITY_BITS] = vel_q[g];
  end

  // Classification of the voice under examination, merged with earlier finds
  always_comb begin
    hit_match = !match_found && gate[idx] && (note_q[idx] == ev_note);
    hit_free  = !free_found && !gate[idx] && !voice_active[idx];
    hit_rel   = !rel_found && !gate[idx] && voice_active[idx];
    hit_old   = gate[idx] && (!old_found || (age_q[idx] > old_age));
    match_sel = hit_match ? idx : match_idx;
    free_sel  = hit_free  ? idx : free_idx;
    rel_sel   = hit_rel   ? idx : rel_idx;
    old_sel   = hit_old   ? idx : old_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      target      <= '0;
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_vel      <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      gate        <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (event_valid) begin
            // Velocity 0 note-on is a note-off
            ev_on       <= event_on && (event_velocity != '0);
            ev_note     <= event_note;
            ev_vel      <= event_velocity;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            old_found   <= 1'b0;
            idx         <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (hit_match) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (hit_free) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (hit_rel) begin
            rel_found <= 1'b1;
            rel_idx   <= idx;
          end
          if (hit_old) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= age_q[idx];
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            if (ev_on) begin
              if (match_found || hit_match) begin
                target <= match_sel;
                state  <= STEAL;
              end else if (free_found || hit_free) begin
                target <= free_sel;
                state  <= ASSIGN;
              end else if (rel_found || hit_rel) begin
                target <= rel_sel;
                state  <= ASSIGN;
              end else begin
                target <= old_sel;
                state  <= STEAL;
              end
            end else if (match_found || hit_match) begin
              target <= match_sel;
              state  <= RELEASE;
            end else begin
              state <= IDLE;
            end
          end
        end
        STEAL: begin
          gate[target] <= 1'b0;
          state        <= ASSIGN;
        end
        ASSIGN: begin
          for (int unsigned i = 0; i < VOICES; i++) begin
            if (IDX_BITS'(i) == target) begin
              age_q[i] <= '0;
            end else if (gate[i] && (age_q[i] != AGE_MAX)) begin
              age_q[i] <= age_q[i] + 1'b1;
            end
          end
          gate[target]   <= 1'b1;
          note_q[target] <= ev_note;
          vel_q[target]  <= ev_vel;
          state          <= IDLE;
        end
        RELEASE: begin
          gate[target] <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
